// File: rtl/tdc_therm_encoder_pkg.sv
// Shared constants and helpers for the TDC thermometer encoder.
// Optional feature macro used by the encoder: TDC_ENC_AVG_EN.
package tdc_pkg;

    localparam int N_DELAY_DEF  = 32;
    localparam int AVG_LOG2_DEF = 3;

    // Width needed to hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    // Three-input majority vote used for bubble correction.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tdc_therm_encoder_if.sv
// Snapshot input and result output channels of the thermometer encoder.
interface tdc_therm_encoder_if
    import tdc_pkg::*;
#(
    parameter int N_DELAY = N_DELAY_DEF,
    parameter int CNT_W   = cnt_w(N_DELAY)
);
    logic               in_valid;
    logic               in_ready;
    logic [N_DELAY-1:0] in_code;
    logic               out_valid;
    logic               out_ready;
    logic [CNT_W-1:0]   out_count;
    logic               out_bubble;
    logic               out_sat;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_count, out_bubble, out_sat
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_count, out_bubble, out_sat
    );
endinterface

// File: rtl/tdc_therm_encoder_popcount.sv
// Combinational population count of the corrected thermometer code.
module tdc_popcount
    import tdc_pkg::*;
#(
    parameter int N_DELAY = N_DELAY_DEF,
    parameter int CNT_W   = cnt_w(N_DELAY)
) (
    input  logic [N_DELAY-1:0] code,
    output logic [CNT_W-1:0]   count
);

    // Sum of all tap bits; the result never exceeds N_DELAY.
    always_comb begin
        count = {CNT_W{1'b0}};
        for (int i = 0; i < N_DELAY; i++) begin
            count = count + CNT_W'(code[i]);
        end
    end

endmodule

// File: rtl/tdc_therm_encoder.sv
// Thermometer-to-binary encoder for the TDC delay line: majority bubble
// correction (S1), popcount and saturation flag into a valid/ready output
// register (S2). Reset rst_n is asynchronous and active-high.
// Optional macro TDC_ENC_AVG_EN: accumulate 2^AVG_LOG2 results and present
// only their truncated average with OR-ed bubble/saturation flags.
module tdc_therm_encoder
    import tdc_pkg::*;
#(
    parameter int N_DELAY  = N_DELAY_DEF,
    parameter int CNT_W    = cnt_w(N_DELAY)
`ifdef TDC_ENC_AVG_EN
    ,
    parameter int AVG_LOG2 = AVG_LOG2_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    tdc_therm_encoder_if.slave bus
);

    logic               ready_en_r;
    logic               advance_s;
    logic               in_ready_s;
    logic               accept_s;
    logic [N_DELAY+1:0] ext_s;
    logic [N_DELAY-1:0] corr_s;
    logic               bubble_s;
    logic               s1_valid_r;
    logic [N_DELAY-1:0] s1_code_r;
    logic               s1_bubble_r;
    logic [CNT_W-1:0]   pop_s;
    logic               sat_s;
    logic               out_valid_r;
    logic [CNT_W-1:0]   out_count_r;
    logic               out_bubble_r;
    logic               out_sat_r;

    // The whole pipeline moves only when the output register can take data.
    assign advance_s     = !out_valid_r || bus.out_ready;
    assign in_ready_s    = ready_en_r && advance_s;
    assign accept_s      = bus.in_valid && in_ready_s;
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_count = out_count_r;
    assign bus.out_bubble = out_bubble_r;
    assign bus.out_sat   = out_sat_r;

    // Input readiness comes up one clock after reset is released.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Majority correction with virtual taps: below bit 0 is 1, above the top is 0.
    always_comb begin
        ext_s  = {1'b0, bus.in_code, 1'b1};
        corr_s = {N_DELAY{1'b0}};
        for (int i = 0; i < N_DELAY; i++) begin
            corr_s[i] = maj3(ext_s[i], ext_s[i+1], ext_s[i+2]);
        end
        bubble_s = |(corr_s ^ bus.in_code);
    end

    // S1: corrected code and bubble flag, held while the output is stalled.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_code_r   <= {N_DELAY{1'b0}};
            s1_bubble_r <= 1'b0;
        end else if (advance_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_code_r   <= corr_s;
                s1_bubble_r <= bubble_s;
            end
        end
    end

    tdc_popcount #(
        .N_DELAY (N_DELAY),
        .CNT_W   (CNT_W)
    ) u_popcount (
        .code  (s1_code_r),
        .count (pop_s)
    );

    assign sat_s = &s1_code_r;

`ifdef TDC_ENC_AVG_EN
    localparam int ACC_W = CNT_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc_r;
    logic [ACC_W-1:0]    acc_sum_s;
    logic [AVG_LOG2-1:0] win_cnt_r;
    logic                win_bub_r;
    logic                win_sat_r;
    logic                win_done_s;

    assign acc_sum_s  = acc_r + ACC_W'(pop_s);
    assign win_done_s = (win_cnt_r == {AVG_LOG2{1'b1}});

    // S2: accumulate a window of samples and publish only the averaged result.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_valid_r  <= 1'b0;
            out_count_r  <= {CNT_W{1'b0}};
            out_bubble_r <= 1'b0;
            out_sat_r    <= 1'b0;
            acc_r        <= {ACC_W{1'b0}};
            win_cnt_r    <= {AVG_LOG2{1'b0}};
            win_bub_r    <= 1'b0;
            win_sat_r    <= 1'b0;
        end else if (advance_s) begin
            out_valid_r <= s1_valid_r && win_done_s;
            if (s1_valid_r) begin
                if (win_done_s) begin
                    out_count_r  <= CNT_W'(acc_sum_s >> AVG_LOG2);
                    out_bubble_r <= win_bub_r | s1_bubble_r;
                    out_sat_r    <= win_sat_r | sat_s;
                    acc_r        <= {ACC_W{1'b0}};
                    win_cnt_r    <= {AVG_LOG2{1'b0}};
                    win_bub_r    <= 1'b0;
                    win_sat_r    <= 1'b0;
                end else begin
                    acc_r     <= acc_sum_s;
                    win_cnt_r <= win_cnt_r + AVG_LOG2'(1'b1);
                    win_bub_r <= win_bub_r | s1_bubble_r;
                    win_sat_r <= win_sat_r | sat_s;
                end
            end
        end
    end
`else
    // S2: per-sample output register, held stable until the consumer takes it.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_valid_r  <= 1'b0;
            out_count_r  <= {CNT_W{1'b0}};
            out_bubble_r <= 1'b0;
            out_sat_r    <= 1'b0;
        end else if (advance_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_count_r  <= pop_s;
                out_bubble_r <= s1_bubble_r;
                out_sat_r    <= sat_s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tdc_therm_encoder.sv
// Self-checking bench for tdc_therm_encoder: directed vectors plus a
// scoreboard fed by a behavioural majority/popcount model.
module tb_tdc_therm_encoder;
    import tdc_pkg::*;

    localparam int N  = N_DELAY_DEF;
    localparam int CW = cnt_w(N);
`ifdef TDC_ENC_AVG_EN
    localparam int AL = AVG_LOG2_DEF;
`else
    localparam int AL = 0;
`endif

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          bub;
        logic          sat;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tdc_therm_encoder_if #(.N_DELAY(N), .CNT_W(CW)) bus ();

    tdc_therm_encoder #(.N_DELAY(N), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   passes = 0;
    res_t q[$];
    int   w_sum = 0;
    int   w_n = 0;
    bit   w_bub = 1'b0;
    bit   w_sat = 1'b0;
    bit   prev_stall = 1'b0;
    logic [CW+1:0] prev_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: each tap votes with its neighbours, then count the ones.
    function automatic res_t ref_sample(input logic [N-1:0] c);
        logic [N-1:0] cc;
        res_t r;
        for (int i = 0; i < N; i++) begin
            int lo = (i == 0) ? 1 : int'(c[i-1]);
            int hi = (i == N - 1) ? 0 : int'(c[i+1]);
            cc[i] = ((lo + int'(c[i]) + hi) >= 2);
        end
        r.cnt = CW'($countones(cc));
        r.bub = (cc != c);
        r.sat = (cc == {N{1'b1}});
        return r;
    endfunction

    task automatic model_accept(input logic [N-1:0] c);
        res_t s = ref_sample(c);
        res_t a;
        if (AL == 0) begin
            q.push_back(s);
        end else begin
            w_sum += int'(s.cnt);
            w_bub |= s.bub;
            w_sat |= s.sat;
            w_n++;
            if (w_n == (1 << AL)) begin
                a.cnt = CW'(w_sum >> AL);
                a.bub = w_bub;
                a.sat = w_sat;
                q.push_back(a);
                w_sum = 0; w_n = 0; w_bub = 1'b0; w_sat = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        w_sum = 0; w_n = 0; w_bub = 1'b0; w_sat = 1'b0;
    endtask

    function automatic logic [N-1:0] rand_therm();
        logic [63:0]  t;
        logic [N-1:0] c;
        int n = $urandom_range(0, N);
        t = (64'd1 << n) - 64'd1;
        c = t[N-1:0];
        if ($urandom_range(0, 4) == 0) c[$urandom_range(0, N - 1)] ^= 1'b1;
        return c;
    endfunction

    // Compare process: hold check, ordered scoreboard, model feed.
    always @(negedge clk) begin
        if (rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("hold", {bus.out_valid, bus.out_count, bus.out_bubble, bus.out_sat},
                      {1'b1, prev_out});
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) check("spurious_out", bus.out_valid, 1'b0);
                else check("result", {bus.out_count, bus.out_bubble, bus.out_sat}, q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) model_accept(bus.in_code);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_count, bus.out_bubble, bus.out_sat};
        end
    end

    // One accepted sample with out_ready high; result must appear exactly 2 edges later.
    task automatic send_lat(input string name, input logic [N-1:0] c, input res_t exp);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_code  = c;
        @(negedge clk);
        check({name, "_in_ready"}, bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({name, "_lat1"}, bus.out_valid, 1'b0);
        @(negedge clk);
        check({name, "_lat2"}, {bus.out_valid, bus.out_count, bus.out_bubble, bus.out_sat},
              {1'b1, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] codes [4];
        int  idx;
        int  seen;
        bit  acc;
        codes[0] = 32'h1; codes[1] = 32'h3; codes[2] = 32'h7; codes[3] = 32'hF;
        bus.in_valid  = 1'b0;
        bus.in_code   = {N{1'b0}};
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b1;
        model_reset();

        // Model pins, hand-computed.
        check("pin_ff",   ref_sample(32'h0000_00FF), {6'd8,  1'b0, 1'b0});
        check("pin_f7",   ref_sample(32'h0000_00F7), {6'd8,  1'b1, 1'b0});
        check("pin_f5",   ref_sample(32'h0000_00F5), {6'd7,  1'b1, 1'b0});
        check("pin_ones", ref_sample(32'hFFFF_FFFF), {6'd32, 1'b0, 1'b1});

        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {bus.out_valid, bus.out_count, bus.out_bubble, bus.out_sat}, 9'd0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b0;
        #1 check("ready_before_edge", bus.in_ready, 1'b0);
        @(posedge clk); #1;
        check("ready_after_edge", bus.in_ready, 1'b1);

`ifndef TDC_ENC_AVG_EN
        send_lat("ff",   32'h0000_00FF, {6'd8,  1'b0, 1'b0});
        send_lat("f7",   32'h0000_00F7, {6'd8,  1'b1, 1'b0});
        send_lat("zero", 32'h0000_0000, {6'd0,  1'b0, 1'b0});
        send_lat("ones", 32'hFFFF_FFFF, {6'd32, 1'b0, 1'b1});
        send_lat("f5",   32'h0000_00F5, {6'd7,  1'b1, 1'b0});

        // Back-to-back 1,2,3,4 with the consumer stalled in cycles 2..5.
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            bus.out_ready = !(c >= 2 && c <= 5);
            bus.in_valid  = (idx < 4);
            bus.in_code   = (idx < 4) ? codes[idx] : {N{1'b0}};
            @(negedge clk);
            if (c == 3) begin
                check("stall_in_ready", bus.in_ready, 1'b0);
                check("stall_out", {bus.out_valid, bus.out_count}, {1'b1, 6'd1});
            end
            if (bus.in_valid && bus.in_ready) idx++;
        end
        check("stall_all_sent", idx, 4);
        check("stall_all_out", q.size(), 0);

        // Reset while two samples are in flight.
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_code = 32'h0000_003F;
        @(posedge clk); #1;
        bus.in_code = 32'h0000_007F;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("pre_rst_valid", bus.out_valid, 1'b1);
        rst_n = 1'b1;
        model_reset();
        #1 check("rst_async_valid", bus.out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("no_stale", seen, 0);
`else
        // Window of 8,8,8,8,9,9,9,9 must give a single result of 68>>3 = 8.
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            bus.in_valid = (c < 8);
            bus.in_code  = (c < 4) ? 32'h0000_00FF : 32'h0000_01FF;
            @(negedge clk);
            if (bus.out_valid) begin
                seen++;
                check("avg_value", {bus.out_count, bus.out_bubble, bus.out_sat}, {6'd8, 1'b0, 1'b0});
            end
        end
        check("avg_pulses", seen, 1);
`endif

        // Random thermometer traffic with random back-pressure.
        acc = 1'b0;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!bus.in_valid || acc) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_code  = rand_therm();
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
        end

        // Drain.
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.out_valid) break;
        end
        check("drain_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
